// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter for the single-read-port instruction ROM (IF fetch = port 0, aux = port 1).
// Optional macro INST_ARB_ROUND_ROBIN_EN selects round-robin base policy; default is fixed priority to port 0.
module inst_rom_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic              stall_if,
  output logic [8:0]        dbg_state
);

  // Handshake: a port holds req with a stable addr until gnt (same-cycle, combinational);
  // the ROM word for that grant is returned as a one-cycle rvalid pulse on the next cycle.

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0]        wait0, wait1;
  logic              last;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              promo0, promo1;
  logic              pick1;

  // pick1 only matters when both ports request in the same cycle.
  always_comb begin
    promo0 = (wait0 >= WAIT_LIM);
    promo1 = (wait1 >= WAIT_LIM);
    pick1  = 1'b0;
    if (promo1 && !promo0) begin
      pick1 = 1'b1;
    end else if (promo0) begin
      pick1 = 1'b0;
    end else begin
`ifdef INST_ARB_ROUND_ROBIN_EN
      pick1 = ~last;
`else
      pick1 = 1'b0;
`endif
    end
  end

  assign p0_gnt   = ~rst & p0_req & (~p1_req | ~pick1);
  assign p1_gnt   = ~rst & p1_req & (~p0_req |  pick1);
  assign rom_ce   = p0_gnt | p1_gnt;
  assign rom_addr = p0_gnt ? p0_addr : (p1_gnt ? p1_addr : '0);
  assign stall_if = p0_req & ~p0_gnt;

  // A response pending during reset is discarded immediately, not one edge later.
  assign p0_rvalid = rvalid0_q & ~rst;
  assign p1_rvalid = rvalid1_q & ~rst;
  assign p0_rdata  = rst ? '0 : rdata0_q;
  assign p1_rdata  = rst ? '0 : rdata1_q;

  assign dbg_state = {last, wait1, wait0};

  always_ff @(posedge clk) begin
    if (rst) begin
      wait0     <= 4'd0;
      wait1     <= 4'd0;
      last      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= p0_gnt;
      rvalid1_q <= p1_gnt;
      if (p0_gnt) rdata0_q <= rom_inst;
      if (p1_gnt) rdata1_q <= rom_inst;

      if (p0_req && !p0_gnt) wait0 <= (wait0 == 4'hF) ? wait0 : wait0 + 4'd1;
      else                   wait0 <= 4'd0;
      if (p1_req && !p1_gnt) wait1 <= (wait1 == 4'hF) ? wait1 : wait1 + 4'd1;
      else                   wait1 <= 4'd0;

      if (p0_gnt)      last <= 1'b0;
      else if (p1_gnt) last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: cycle-level reference model with per-port response queues,
// plus directed scenarios with literal expectations.
module tb_inst_rom_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 4;

  logic          clk, rst;
  logic          p0_req, p1_req;
  logic [AW-1:0] p0_addr, p1_addr;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          rom_ce, stall_if;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_inst;
  logic [8:0]    dbg_state;

  logic [DW-1:0] rom_mem [64];

  int total = 0;
  int bad   = 0;

  inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst), .stall_if(stall_if),
    .dbg_state(dbg_state)
  );

  assign rom_inst = rom_mem[rom_addr[7:2]];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_wait0 = 0, m_wait1 = 0;
  bit            m_last = 1'b1;
  bit            m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            started = 1'b0;

  // Winner for the current cycle: -1 none, 0 or 1.
  function automatic int winner();
    bit s0, s1;
    if (rst === 1'b1 || (!p0_req && !p1_req)) return -1;
    if (p0_req && !p1_req) return 0;
    if (p1_req && !p0_req) return 1;
    s0 = (m_wait0 >= MAXW);
    s1 = (m_wait1 >= MAXW);
    if (s1 && !s0) return 1;
    if (s0) return 0;
`ifdef INST_ARB_ROUND_ROBIN_EN
    return (m_last == 1'b0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    int w;
    w = winner();
    started = 1'b1;
    if (rst) begin
      m_wait0 = 0; m_wait1 = 0; m_last = 1'b1;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      m_rv0 = (w == 0);
      m_rv1 = (w == 1);
      if (w == 0) exp_q0.push_back(rom_mem[p0_addr[7:2]]);
      if (w == 1) exp_q1.push_back(rom_mem[p1_addr[7:2]]);
      m_wait0 = (p0_req && w != 0) ? ((m_wait0 < 15) ? m_wait0 + 1 : 15) : 0;
      m_wait1 = (p1_req && w != 1) ? ((m_wait1 < 15) ? m_wait1 + 1 : 15) : 0;
      if (w >= 0) m_last = w[0];
    end
  end

  // Compare process: outputs checked every cycle on the falling edge.
  always @(negedge clk) begin
    int w;
    logic [AW-1:0] ea;
    if (started) begin
      w  = winner();
      ea = (w == 0) ? p0_addr : ((w == 1) ? p1_addr : '0);
      if (m_rv0 && !rst) begin
        chk("q0_depth", 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) m_rd0 = exp_q0.pop_front();
      end
      if (m_rv1 && !rst) begin
        chk("q1_depth", 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) m_rd1 = exp_q1.pop_front();
      end
      chk("m_p0_gnt", 64'(p0_gnt), 64'(w == 0));
      chk("m_p1_gnt", 64'(p1_gnt), 64'(w == 1));
      chk("m_rom_ce", 64'(rom_ce), 64'(w >= 0));
      chk("m_rom_addr", 64'(rom_addr), 64'(ea));
      chk("m_stall_if", 64'(stall_if), 64'(p0_req && w != 0));
      chk("m_p0_rvalid", 64'(p0_rvalid), 64'(m_rv0 && !rst));
      chk("m_p1_rvalid", 64'(p1_rvalid), 64'(m_rv1 && !rst));
      chk("m_p0_rdata", 64'(p0_rdata), rst ? 64'd0 : 64'(m_rd0));
      chk("m_p1_rdata", 64'(p1_rdata), rst ? 64'd0 : 64'(m_rd1));
      chk("m_dbg_state", 64'(dbg_state), 64'({m_last, 4'(m_wait1), 4'(m_wait0)}));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] want [3];
  logic [9:0]    pat, spat;
  logic [2:0]    tbl [20];
  int            n;

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    rom_mem[2] = 32'h3C01_0001;
    want[0] = 32'h1000_0000; want[1] = 32'h1000_0101; want[2] = 32'h3C01_0001;

    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; p0_addr = '0; p1_addr = '0;
    step();
    // Reset holds grants low even with a request pending.
    p0_req = 1'b1;
    #1;
    chk("rst_p0_gnt", 64'(p0_gnt), 64'd0);
    chk("rst_rom_ce", 64'(rom_ce), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    chk("rst_dbg", 64'(dbg_state), 64'h100);
    step();

    // Solo fetch of ROM[2].
    rst = 1'b0; p0_req = 1'b1; p0_addr = 32'h8;
    #1;
    chk("solo_gnt", 64'(p0_gnt), 64'd1);
    chk("solo_rom_addr", 64'(rom_addr), 64'h8);
    chk("solo_rom_ce", 64'(rom_ce), 64'd1);
    chk("solo_stall", 64'(stall_if), 64'd0);
    step();
    p0_req = 1'b0;
    #1;
    chk("solo_rvalid", 64'(p0_rvalid), 64'd1);
    chk("solo_rdata", 64'(p0_rdata), 64'h3C01_0001);
    step();
    #1;
    chk("solo_rvalid_end", 64'(p0_rvalid), 64'd0);
    chk("solo_rdata_hold", 64'(p0_rdata), 64'h3C01_0001);

    // Back-to-back fetches 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      p0_req = 1'b1; p0_addr = 32'(i * 4);
      #1;
      if (i > 0) begin
        chk("b2b_rvalid", 64'(p0_rvalid), 64'd1);
        chk("b2b_rdata", 64'(p0_rdata), 64'(want[i-1]));
      end
      step();
    end
    p0_req = 1'b0;
    #1;
    chk("b2b_rvalid_last", 64'(p0_rvalid), 64'd1);
    chk("b2b_rdata_last", 64'(p0_rdata), 64'(want[2]));
    step();

    // Continuous contention from reset.
    rst = 1'b1;
    step();
    rst = 1'b0; p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h0C; p1_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      pat[i]  = p1_gnt;
      spat[i] = stall_if;
      chk("cont_one_gnt", 64'(p0_gnt ^ p1_gnt), 64'd1);
      step();
    end
`ifdef INST_ARB_ROUND_ROBIN_EN
    chk("cont_p1_pattern", 64'(pat), 64'h2AA);
    chk("cont_stall_pattern", 64'(spat), 64'h2AA);
`else
    chk("cont_p1_pattern", 64'(pat), 64'h210);
    chk("cont_stall_pattern", 64'(spat), 64'h210);
`endif
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Reset right after a port 1 grant.
    p1_req = 1'b1; p1_addr = 32'h10;
    #1;
    chk("rstmid_p1_gnt", 64'(p1_gnt), 64'd1);
    step();
    rst = 1'b1; p1_req = 1'b0;
    #1;
    chk("rstmid_p1_rvalid", 64'(p1_rvalid), 64'd0);
    chk("rstmid_p1_rdata", 64'(p1_rdata), 64'd0);
    chk("rstmid_rom_ce", 64'(rom_ce), 64'd0);
    step();
    rst = 1'b0; p0_req = 1'b1; p1_req = 1'b1;
    #1;
    chk("rstmid_first_p0", 64'(p0_gnt), 64'd1);
    chk("rstmid_first_p1", 64'(p1_gnt), 64'd0);
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Dropped request: load a known p1_rdata, then lose twice and withdraw.
    p1_req = 1'b1; p1_addr = 32'h14;
    step();
    p1_req = 1'b0;
    #1;
    chk("drop_pre_rdata", 64'(p1_rdata), 64'h1000_0505);
    step();
    p0_req = 1'b1; p0_addr = 32'h0; p1_req = 1'b1; p1_addr = 32'h30;
    for (int i = 0; i < 2; i++) begin
      #1;
`ifndef INST_ARB_ROUND_ROBIN_EN
      chk("drop_p1_loses", 64'(p1_gnt), 64'd0);
`endif
      step();
    end
    p1_req = 1'b0;
`ifndef INST_ARB_ROUND_ROBIN_EN
    #1;
    chk("drop_wait1_two", 64'(dbg_state[7:4]), 64'd2);
    step();
    #1;
    chk("drop_wait1_clear", 64'(dbg_state[7:4]), 64'd0);
    chk("drop_no_rvalid", 64'(p1_rvalid), 64'd0);
    chk("drop_rdata_hold", 64'(p1_rdata), 64'h1000_0505);
`endif
    step();
    // Port 1 must wait a full MAX_WAIT again after the drop.
    p1_req = 1'b1;
    n = 0;
    while (n < 20) begin
      #1;
      if (p1_gnt) break;
      n++;
      step();
    end
    chk("drop_timeout", 64'(n < 20), 64'd1);
`ifdef INST_ARB_ROUND_ROBIN_EN
    chk("drop_p1_wait_cycles", 64'(n), 64'd0);
`else
    chk("drop_p1_wait_cycles", 64'(n), 64'd4);
`endif
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Mixed directed table {rst, p0_req, p1_req}; the model checks every cycle.
    tbl = '{3'b011, 3'b011, 3'b001, 3'b010, 3'b011, 3'b111, 3'b011, 3'b011,
            3'b011, 3'b011, 3'b011, 3'b011, 3'b000, 3'b001, 3'b001, 3'b011,
            3'b010, 3'b110, 3'b011, 3'b011};
    for (int i = 0; i < 20; i++) begin
      rst     = tbl[i][2];
      p0_req  = tbl[i][1];
      p1_req  = tbl[i][0];
      p0_addr = 32'((i * 4) & 32'h3C);
      p1_addr = 32'(((i * 8) + 4) & 32'h3C);
      step();
    end
    rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
